// File: rtl/vga_line_fetch_if.sv
// Read-port bundle between the line fetcher (master) and frame-buffer memory (slave).
// One read outstanding: req/addr held until gnt, then a single rvalid returns the byte.
interface vga_line_fetch_if;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, output mem_addr,
                  input  mem_gnt, input mem_rvalid, input mem_rdata);
  modport slave  (input  mem_req, input mem_addr,
                  output mem_gnt, output mem_rvalid, output mem_rdata);
endinterface

// File: rtl/vga_line_fetch.sv
// Ping-pong line buffer that fetches SRC_W-wide source rows and scales them 2x to 640x480.
// Optional test pattern on test_mode when VGA_LINE_FETCH_TESTPAT_EN is defined.
module vga_line_fetch #(
  parameter int SRC_W = 320,
  parameter int SRC_H = 240
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [9:0]            next_x,
  input  logic [9:0]            next_y,
  input  logic                  vsync,
  input  logic [16:0]           fb_base,
`ifdef VGA_LINE_FETCH_TESTPAT_EN
  input  logic                  test_mode,
`endif
  output logic [7:0]            color_out,
  output logic                  overrun,
  vga_line_fetch_if.master      mem
);

  localparam int         IDX_W    = $clog2(2 * SRC_W);
  localparam logic [9:0] LAST_COL = 10'(SRC_W - 1);
  localparam logic [9:0] LAST_ROW = 10'(SRC_H - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  function automatic logic [16:0] row_addr(input logic [16:0] base,
                                           input logic [9:0]  row,
                                           input logic [9:0]  col);
    return 17'(32'(base) + 32'(row) * 32'(SRC_W) + 32'(col));
  endfunction

  state_t      state_q, state_d;
  logic [16:0] base_q, base_d;
  logic [9:0]  row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        pend_q, pend_d;
  logic        abort_q, abort_d;
  logic        started_q, started_d;
  logic        vsync_q, vsync_d;
  logic [9:0]  next_y_q, next_y_d;
  logic        overrun_q, overrun_d;
  logic        req_q, req_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  color_q, color_d;

  logic [7:0]  line_mem [0:2*SRC_W-1];

  logic             vfall, trig, vis, rd_ok, wr_en;
  logic [9:0]       trig_r, trig_row, rd_col;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [7:0]       pix;
  logic             unused_bits;

  // Horizontal 2x replication discards the LSB of the column.
  assign unused_bits = next_x[0];

  assign vfall    = vsync_q & ~vsync;
  assign trig_r   = {1'b0, next_y[9:1]};
  assign trig_row = trig_r + 10'd1;
  assign trig     = started_q && (next_y != next_y_q) && !next_y[0] &&
                    (trig_r != 10'd0) && (trig_r < LAST_ROW);

  assign vis    = (next_x < 10'd640) && (next_y < 10'd480);
  assign rd_col = {1'b0, next_x[9:1]};
  assign rd_ok  = vis && (rd_col <= LAST_COL);
  assign rd_idx = (next_y[1] ? IDX_W'(SRC_W) : '0) + IDX_W'(rd_col);
  assign pix    = rd_ok ? line_mem[rd_idx] : 8'd0;

  assign wr_en  = (state_q == WAIT) && mem.mem_rvalid && !reset;
  assign wr_idx = (row_q[0] ? IDX_W'(SRC_W) : '0) + IDX_W'(col_q);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    row_d     = row_q;
    col_d     = col_q;
    pend_d    = pend_q;
    abort_d   = abort_q;
    started_d = started_q | vfall;
    vsync_d   = vsync;
    next_y_d  = next_y;
    overrun_d = overrun_q | (trig && (state_q != IDLE));
    color_d   = pix;
`ifdef VGA_LINE_FETCH_TESTPAT_EN
    if (test_mode)
      color_d = vis ? {next_x[9:7], next_y[8:6], next_x[6:5]} : 8'd0;
`endif

    case (state_q)
      IDLE: begin
        if (vfall) begin
          base_d  = fb_base;
          row_d   = 10'd0;
          col_d   = 10'd0;
          pend_d  = 1'b1;
          abort_d = 1'b0;
          state_d = REQ;
        end else if (trig) begin
          row_d   = trig_row;
          col_d   = 10'd0;
          pend_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A new frame cannot preempt a request on the bus; it restarts after the read returns.
        if (vfall) begin
          base_d  = fb_base;
          abort_d = 1'b1;
        end
        if (mem.mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (vfall) begin
          base_d  = fb_base;
          abort_d = 1'b1;
        end
        if (mem.mem_rvalid) begin
          state_d = REQ;
          if (abort_d) begin
            row_d   = 10'd0;
            col_d   = 10'd0;
            pend_d  = 1'b1;
            abort_d = 1'b0;
          end else if (col_q != LAST_COL) begin
            col_d = col_q + 10'd1;
          end else if (pend_q) begin
            row_d  = 10'd1;
            col_d  = 10'd0;
            pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Address is computed once on entry to REQ so it stays frozen until the grant.
    addr_d = addr_q;
    if ((state_d == REQ) && (state_q != REQ))
      addr_d = row_addr(base_d, row_d, col_d);
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      pend_q    <= 1'b0;
      abort_q   <= 1'b0;
      started_q <= 1'b0;
      vsync_q   <= 1'b0;
      next_y_q  <= '0;
      overrun_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      color_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pend_q    <= pend_d;
      abort_q   <= abort_d;
      started_q <= started_d;
      vsync_q   <= vsync_d;
      next_y_q  <= next_y_d;
      overrun_q <= overrun_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      color_q   <= color_d;
    end
  end

  // Line storage and the sampled base are data only; reset leaves them intact.
  always_ff @(posedge clock) begin
    base_q <= base_d;
    if (wr_en) line_mem[wr_idx] <= mem.mem_rdata;
  end

  assign color_out    = color_q;
  assign overrun      = overrun_q;
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: expected fetch addresses and pixels are queued at
// stimulus time and popped when the memory model sees a grant or the pixel pipe emits.
module tb_vga_line_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  next_x = '0;
  logic [9:0]  next_y = '0;
  logic        vsync = 1'b1;
  logic [16:0] fb_base = '0;
  logic [7:0]  color_out;
  logic        overrun;
`ifdef VGA_LINE_FETCH_TESTPAT_EN
  logic        test_mode = 1'b0;
`endif

  vga_line_fetch_if bus ();

  vga_line_fetch #(.SRC_W(320), .SRC_H(240)) dut (
    .clock     (clock),
    .reset     (reset),
    .next_x    (next_x),
    .next_y    (next_y),
    .vsync     (vsync),
    .fb_base   (fb_base),
`ifdef VGA_LINE_FETCH_TESTPAT_EN
    .test_mode (test_mode),
`endif
    .color_out (color_out),
    .overrun   (overrun),
    .mem       (bus.master)
  );

  always #20 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [16:0] exp_q [$];
  logic [7:0]  exp_c [$];
  logic [7:0]  fbmem [0:131071];
  int          gcnt = 0;
  logic        gnt_en = 1'b1;
  logic        force_rv = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: grant in the cycle a request is seen, data one cycle later.
  initial begin
    logic        rd_pend;
    logic [16:0] pend_addr;
    logic [31:0] exp_a;
    rd_pend = 1'b0;
    pend_addr = '0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      bus.mem_rvalid = 1'b0;
      if (rd_pend) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = fbmem[pend_addr];
        rd_pend = 1'b0;
      end else if (force_rv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 8'hEE;
      end
      bus.mem_gnt = gnt_en & bus.mem_req;
      if (bus.mem_gnt) begin
        exp_a = (exp_q.size() > 0) ? {15'd0, exp_q.pop_front()} : 32'hDEADBEEF;
        check_val("mem_addr", {15'd0, bus.mem_addr}, exp_a);
        gcnt++;
        rd_pend = 1'b1;
        pend_addr = bus.mem_addr;
      end
    end
  end

  task automatic push_row(input logic [16:0] base, input int row);
    for (int c = 0; c < 320; c++) exp_q.push_back(17'(int'(base) + row * 320 + c));
  endtask

  task automatic vsync_fall(input logic [16:0] base);
    @(posedge clock); #1;
    fb_base = base;
    vsync = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    vsync = 1'b1;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.mem_req) && n < bound) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    check_val({tag, "_drain"}, exp_q.size(), 0);
    check_val({tag, "_idle"}, {31'd0, bus.mem_req}, 0);
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [7:0] exp,
                     input string tag);
    @(posedge clock); #1;
    next_x = x;
    next_y = y;
    exp_c.push_back(exp);
    @(posedge clock);
    @(negedge clock);
    check_val(tag, {24'd0, color_out}, {24'd0, exp_c.pop_front()});
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int n;
    for (int a = 0; a < 131072; a++) fbmem[a] = 8'(a - 256);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_req", {31'd0, bus.mem_req}, 0);
    check_val("rst_addr", {15'd0, bus.mem_addr}, 0);
    check_val("rst_color", {24'd0, color_out}, 0);
    check_val("rst_ovr", {31'd0, overrun}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    g0 = gcnt;
    repeat (10) @(negedge clock);
    check_val("no_fetch_pre_vsync", gcnt - g0, 0);

    push_row(17'h100, 0);
    push_row(17'h100, 1);
    g0 = gcnt;
    vsync_fall(17'h100);
    wait_idle(3000, "init_fetch");
    check_val("init_req_cnt", gcnt - g0, 640);

    pix(10'd7, 10'd0, 8'd3, "pix_x7");
    pix(10'd700, 10'd0, 8'd0, "pix_hblank");
    pix(10'd10, 10'd480, 8'd0, "pix_vblank");
    pix(10'd601, 10'd1, 8'd44, "pix_row0_c300");
    pix(10'd10, 10'd3, 8'd69, "pix_row1_c5");
    pix(10'd639, 10'd3, 8'd127, "pix_row1_c319");

    push_row(17'h100, 3);
    g0 = gcnt;
    @(posedge clock); #1;
    next_y = 10'd4;
    wait_idle(2000, "row3_fetch");
    check_val("row3_req_cnt", gcnt - g0, 320);
    pix(10'd20, 10'd3, 8'd202, "pix_row3_c10");

    push_row(17'h100, 239);
    g0 = gcnt;
    @(posedge clock); #1;
    next_y = 10'd476;
    wait_idle(2000, "row239_fetch");
    check_val("row239_req_cnt", gcnt - g0, 320);
    g0 = gcnt;
    pix(10'd0, 10'd478, 8'd192, "pix_row239_c0");
    repeat (20) @(negedge clock);
    check_val("y478_no_fetch", gcnt - g0, 0);

    // New frame arrives while a request is stalled on the bus.
    @(posedge clock); #1;
    gnt_en = 1'b0;
    exp_q.push_back(17'h1FF00);
    push_row(17'h200, 0);
    push_row(17'h200, 1);
    g0 = gcnt;
    vsync_fall(17'h1FF00);
    repeat (5) @(negedge clock);
    vsync_fall(17'h200);
    repeat (5) @(negedge clock);
    @(posedge clock); #1;
    gnt_en = 1'b1;
    wait_idle(3000, "abort_fetch");
    check_val("abort_req_cnt", gcnt - g0, 641);
    check_val("abort_no_ovr", {31'd0, overrun}, 0);

    @(posedge clock); #1;
    gnt_en = 1'b0;
    push_row(17'h1FF00, 0);
    push_row(17'h1FF00, 1);
    vsync_fall(17'h1FF00);
    repeat (2000) @(negedge clock);
    check_val("stall_req", {31'd0, bus.mem_req}, 1);
    check_val("stall_addr", {15'd0, bus.mem_addr}, 32'h1FF00);
    check_val("stall_no_ovr", {31'd0, overrun}, 0);
    @(posedge clock); #1;
    next_y = 10'd2;
    @(posedge clock); #1;
    next_y = 10'd4;
    repeat (2) @(negedge clock);
    check_val("ovr_set", {31'd0, overrun}, 1);
    @(posedge clock); #1;
    gnt_en = 1'b1;
    wait_idle(3000, "wrap_fetch");
    check_val("ovr_sticky", {31'd0, overrun}, 1);

    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_val("ovr_cleared", {31'd0, overrun}, 0);

    // Reset lands while column 100 is outstanding.
    push_row(17'h105, 0);
    push_row(17'h105, 1);
    g0 = gcnt;
    vsync_fall(17'h105);
    n = 0;
    while ((gcnt - g0) < 101 && n < 1000) begin
      @(negedge clock); #1;
      n++;
    end
    check_val("rst_reach_c100", gcnt - g0, 101);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    force_rv = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    force_rv = 1'b0;
    exp_q.delete();
    g0 = gcnt;
    repeat (10) @(negedge clock);
    check_val("rst_no_refetch", gcnt - g0, 0);
    check_val("rst_req_low", {31'd0, bus.mem_req}, 0);
    pix(10'd200, 10'd1, 8'd100, "rst_keep_c100");
    pix(10'd198, 10'd1, 8'd104, "rst_c99_new");
    pix(10'd202, 10'd1, 8'd101, "rst_keep_c101");

`ifdef VGA_LINE_FETCH_TESTPAT_EN
    @(posedge clock); #1;
    test_mode = 1'b1;
    pix(10'h1A0, 10'h0C0, 8'h6D, "testpat");
    pix(10'd700, 10'h0C0, 8'h00, "testpat_blank");
    @(posedge clock); #1;
    test_mode = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 The block SHALL have parameter SRC_W, default 320, meaning source image width in pixels.
REQ-002 The block SHALL have parameter SRC_H, default 240, meaning source image height in lines.
REQ-003 The block SHALL have port clock, input, 1 bit: 25 MHz pixel clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port next_x, input, 10 bits: next display column from the VGA timing stage.
REQ-006 The block SHALL have port next_y, input, 10 bits: next display row from the VGA timing stage (0 during blanking).
REQ-007 The block SHALL have port vsync, input, 1 bit: active-low vertical sync.
REQ-008 The block SHALL have port fb_base, input, 17 bits: frame buffer byte base address.
REQ-009 The block SHALL have port color_out, output, 8 bits: pixel in RRRGGGBB format, feeding color_in of the VGA stage.
REQ-010 The block SHALL have port mem_req, output, 1 bit: read request.
REQ-011 The block SHALL have port mem_addr, output, 17 bits: read byte address.
REQ-012 The block SHALL have port mem_gnt, input, 1 bit: request accepted this cycle.
REQ-013 The block SHALL have port mem_rvalid, input, 1 bit: read data valid.
REQ-014 The block SHALL have port mem_rdata, input, 8 bits: read data.
REQ-015 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a fetch trigger is lost.

Function
REQ-016 The block SHALL hold a ping-pong line buffer, 2 x SRC_W x 8 bits; source row r SHALL be stored in bank r[0].
REQ-017 The block SHALL register color_out = buffer[bank next_y[1]][next_x>>1], giving 1-cycle latency from next_x/next_y and 2x replication horizontally and vertically.
REQ-018 color_out SHALL be 0 when next_x >= 640 or next_y >= 480.
REQ-019 A vsync 1->0 edge SHALL sample fb_base, reset the row counter, and start a two-row fetch of row 0 then row 1.
REQ-020 A registered change of next_y to an even value 2r, with r >= 1 and r+1 <= SRC_H-1, SHALL start a fetch of row r+1.
REQ-021 The fetch FSM SHALL have states IDLE, REQ, WAIT; IDLE->REQ on trigger; REQ->WAIT on mem_gnt; WAIT->REQ on mem_rvalid if bytes remain, else WAIT->IDLE (WAIT->REQ when a pending second row from REQ-019 remains).
REQ-022 Only one read SHALL be outstanding; mem_req SHALL be high only in REQ and SHALL hold mem_addr stable until mem_gnt.
REQ-023 mem_addr SHALL equal sampled_base + row*SRC_W + col (17-bit, wrapping modulo 2^17); col SHALL run 0..SRC_W-1.
REQ-024 mem_rdata SHALL be written to buffer[row[0]][col] on mem_rvalid; mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-025 A REQ-020 trigger arriving while the FSM is not IDLE SHALL be dropped and SHALL set overrun.
REQ-026 A vsync falling edge while busy SHALL abort the current fetch after its outstanding read returns and restart per REQ-019, without setting overrun.
REQ-027 A display read and a fetch write to the same buffer entry in the same cycle SHALL return the old data.

Reset
REQ-028 On reset, the FSM SHALL enter IDLE and mem_req, mem_addr, color_out, overrun, the row and column counters, and the edge-detect registers SHALL all be 0.
REQ-029 Reset SHALL not clear line buffer contents.
REQ-030 Reset asserted mid-fetch SHALL drop the request immediately and ignore any late mem_rvalid.
REQ-031 After reset, no fetch SHALL start until the first vsync falling edge.

Configuration
REQ-032 With macro VGA_LINE_FETCH_TESTPAT_EN defined, the block SHALL add input test_mode (1 bit); while test_mode=1, color_out SHALL be {next_x[9:7], next_y[8:6], next_x[6:5]}, with blanking per REQ-018, and fetches SHALL continue.
REQ-033 With VGA_LINE_FETCH_TESTPAT_EN undefined, the block SHALL have no test_mode port and no pattern logic.

Verification
REQ-034 Bench SHALL cover: reset, then vsync falling edge with fb_base=0x100 and mem_gnt/mem_rvalid at 1-cycle latency -> 640 requests at addresses 0x100..0x37F, then IDLE.
REQ-035 Bench SHALL cover: after row 0 loaded with byte value = col, next_y=0, next_x=7 -> color_out=3 one cycle later; next_x=700 -> color_out=0.
REQ-036 Bench SHALL cover: next_y changes 3->4 -> fetch of row 3 into bank 1 starting at base+960; next_y=478 -> no fetch.
REQ-037 Bench SHALL cover: mem_gnt held low for 2000 cycles, then next_y 2->4 -> overrun=1 and stays 1 until reset.
REQ-038 Bench SHALL cover: reset asserted at col 100 of a fetch, then mem_rvalid pulse -> mem_req=0, buffer unchanged, FSM IDLE.
REQ-039 Bench SHALL cover: with VGA_LINE_FETCH_TESTPAT_EN, test_mode=1, next_x=0x1A0, next_y=0x0C0 -> color_out=0x6D.
